// File: rtl/ld3320_pkg.sv
// ld3320_pkg: shared opcodes, command-entry layout and sequencer state encoding
// for the LD3320 command sequencer.
package ld3320_pkg;

    localparam logic [1:0] OP_WR   = 2'd0;
    localparam logic [1:0] OP_POLL = 2'd1;
    localparam logic [1:0] OP_DLY  = 2'd2;
    localparam logic [1:0] OP_END  = 2'd3;

    localparam int ENT_W   = 26;
    localparam int OP_HI   = 25;
    localparam int OP_LO   = 24;
    localparam int ADDR_HI = 23;
    localparam int ADDR_LO = 16;
    localparam int DATA_HI = 15;
    localparam int DATA_LO = 8;
    localparam int MASK_HI = 7;
    localparam int MASK_LO = 0;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] mask;
    } cmd_entry_t;

    typedef enum logic [9:0] {
        S_IDLE     = 10'b00_0000_0001,
        S_FETCH    = 10'b00_0000_0010,
        S_DECODE   = 10'b00_0000_0100,
        S_ISSUE    = 10'b00_0000_1000,
        S_WAIT_BUS = 10'b00_0001_0000,
        S_CHECK    = 10'b00_0010_0000,
        S_DELAY    = 10'b00_0100_0000,
        S_NEXT     = 10'b00_1000_0000,
        S_DONE     = 10'b01_0000_0000,
        S_ERR      = 10'b10_0000_0000
    } seq_state_t;

    // A poll succeeds when the masked read value equals the masked expected value.
    function automatic logic poll_match(input logic [7:0] rdata,
                                        input logic [7:0] data,
                                        input logic [7:0] mask);
        return (rdata & mask) == (data & mask);
    endfunction

endpackage

// File: rtl/ld3320_ms_tick.sv
// ld3320_ms_tick: free-running millisecond tick. A restart reloads the divider
// so the first millisecond after a restart is full length.
module ld3320_ms_tick #(
    parameter int CLK_FREQ_HZ = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int DIV = (CLK_FREQ_HZ / 1000 > 0) ? CLK_FREQ_HZ / 1000 : 1;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Down-counter; terminal count marks the tick and reloads the divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RELOAD;
        end else if (restart || cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/ld3320_cmd_sequencer.sv
// ld3320_cmd_sequencer: walks a command table held in an external synchronous
// ROM and drives the LD3320 parallel-bus driver handshake.
// Optional build macro: LD3320_SEQ_READBACK_EN - every write is followed by a
// read of the same register; a differing value ends the sequence in error.
//
// state    | meaning
// IDLE     | waiting for start
// FETCH    | ROM address presented, data arrives next cycle
// DECODE   | latch entry, dispatch on opcode
// ISSUE    | one-cycle bus_ena pulse
// WAIT_BUS | bus fields held until bus_done
// CHECK    | evaluate write / poll result
// DELAY    | millisecond wait (DLY entry or poll retry gap)
// NEXT     | advance table index
// DONE     | seq_done pulse
// ERR      | seq_err pulse, err_idx captured
module ld3320_cmd_sequencer
    import ld3320_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int ROM_AW      = 6,
    parameter int POLL_MAX    = 100,
    parameter int POLL_GAP_MS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ROM_AW-1:0] start_idx,
    output logic              busy,
    output logic              seq_done,
    output logic              seq_err,
    output logic [ROM_AW-1:0] err_idx,
    output logic [7:0]        last_rdata,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [25:0]       rom_data,
    output logic              bus_ena,
    output logic              bus_sel,
    output logic [7:0]        bus_addr,
    output logic [7:0]        bus_wdata,
    input  logic [7:0]        bus_rdata,
    input  logic              bus_data_ready,
    input  logic              bus_done
);

    localparam int PCW = $clog2(POLL_MAX + 1);
    localparam logic [PCW:0] POLL_LIMIT = (PCW + 1)'(POLL_MAX);
    localparam logic [15:0]  POLL_GAP   = 16'(POLL_GAP_MS);

    seq_state_t     state, state_nxt;
    cmd_entry_t     rom_ent;
    logic [1:0]     ent_op;
    logic [7:0]     ent_data;
    logic [7:0]     ent_mask;
    logic [15:0]    dly_cnt;
    logic           dly_retry;
    logic [PCW-1:0] poll_cnt;
    logic [PCW:0]   poll_inc;
    logic           poll_hit;
    logic           ms_tick;
    logic           tick_restart;
`ifdef LD3320_SEQ_READBACK_EN
    logic           rb_phase;
`endif

    assign rom_ent      = cmd_entry_t'(rom_data);
    assign poll_inc     = {1'b0, poll_cnt} + 1'b1;
    assign poll_hit     = poll_match(last_rdata, ent_data, ent_mask);
    assign bus_ena      = (state == S_ISSUE);
    assign seq_done     = (state == S_DONE);
    assign seq_err      = (state == S_ERR);
    assign tick_restart = (state != S_DELAY) && (state_nxt == S_DELAY);

    ld3320_ms_tick #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_ms_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (tick_restart),
        .tick    (ms_tick)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; bus_done only matters while waiting on the bus.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: state_nxt = S_DECODE;
            S_DECODE: begin
                case (rom_ent.op)
                    OP_WR, OP_POLL: state_nxt = S_ISSUE;
                    OP_DLY: begin
                        if ({rom_ent.addr, rom_ent.data} == 16'd0) state_nxt = S_NEXT;
                        else                                        state_nxt = S_DELAY;
                    end
                    default: state_nxt = S_DONE;
                endcase
            end
            S_ISSUE: state_nxt = S_WAIT_BUS;
            S_WAIT_BUS: begin
                if (bus_done) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (ent_op == OP_WR) begin
`ifdef LD3320_SEQ_READBACK_EN
                    if (!rb_phase)                   state_nxt = S_ISSUE;
                    else if (last_rdata != ent_data) state_nxt = S_ERR;
                    else                             state_nxt = S_NEXT;
`else
                    state_nxt = S_NEXT;
`endif
                end else if (poll_hit) begin
                    state_nxt = S_NEXT;
                end else if (poll_inc >= POLL_LIMIT) begin
                    state_nxt = S_ERR;
                end else if (POLL_GAP == 16'd0) begin
                    state_nxt = S_ISSUE;
                end else begin
                    state_nxt = S_DELAY;
                end
            end
            S_DELAY: begin
                if (ms_tick && dly_cnt <= 16'd1) state_nxt = dly_retry ? S_ISSUE : S_NEXT;
            end
            S_NEXT:  state_nxt = S_FETCH;
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: table index, latched entry, bus fields, counters and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            err_idx    <= '0;
            last_rdata <= 8'h00;
            rom_addr   <= '0;
            bus_sel    <= 1'b0;
            bus_addr   <= 8'h00;
            bus_wdata  <= 8'h00;
            ent_op     <= OP_WR;
            ent_data   <= 8'h00;
            ent_mask   <= 8'h00;
            dly_cnt    <= 16'd0;
            dly_retry  <= 1'b0;
            poll_cnt   <= '0;
`ifdef LD3320_SEQ_READBACK_EN
            rb_phase   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        rom_addr <= start_idx;
                        err_idx  <= '0;
                        poll_cnt <= '0;
                    end
                end
                S_DECODE: begin
                    ent_op   <= rom_ent.op;
                    ent_data <= rom_ent.data;
                    ent_mask <= rom_ent.mask;
`ifdef LD3320_SEQ_READBACK_EN
                    rb_phase <= 1'b0;
`endif
                    if (rom_ent.op == OP_WR || rom_ent.op == OP_POLL) begin
                        bus_sel   <= (rom_ent.op == OP_WR);
                        bus_addr  <= rom_ent.addr;
                        bus_wdata <= rom_ent.data;
                    end
                    if (rom_ent.op == OP_DLY) begin
                        dly_cnt   <= {rom_ent.addr, rom_ent.data};
                        dly_retry <= 1'b0;
                    end
                end
                S_WAIT_BUS: begin
                    if (bus_done && !bus_sel && bus_data_ready) last_rdata <= bus_rdata;
                end
                S_CHECK: begin
`ifdef LD3320_SEQ_READBACK_EN
                    if (ent_op == OP_WR && !rb_phase) begin
                        rb_phase <= 1'b1;
                        bus_sel  <= 1'b0;
                    end
`endif
                    if (ent_op == OP_POLL && !poll_hit) begin
                        poll_cnt  <= poll_cnt + 1'b1;
                        dly_cnt   <= POLL_GAP;
                        dly_retry <= 1'b1;
                    end
                    if (state_nxt == S_ERR) err_idx <= rom_addr;
                end
                S_DELAY: begin
                    if (ms_tick) dly_cnt <= dly_cnt - 1'b1;
                end
                S_NEXT: begin
                    rom_addr <= rom_addr + 1'b1;
                    poll_cnt <= '0;
                end
                S_DONE: busy <= 1'b0;
                S_ERR:  busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ld3320_cmd_sequencer.sv
// tb_ld3320_cmd_sequencer: randomized and directed bench with a table-walking
// reference model, a ROM model and an 8-cycle bus driver model.
`timescale 1ns/1ps
module tb_ld3320_cmd_sequencer;
    import ld3320_pkg::*;

    localparam int CLK_FREQ_HZ = 1000000;
    localparam int ROM_AW      = 6;
    localparam int POLL_MAX    = 4;
    localparam int POLL_GAP_MS = 1;
    localparam int MS          = CLK_FREQ_HZ / 1000;
    localparam int LAT         = 8;

    typedef struct packed {
        logic       sel;
        logic [7:0] addr;
        logic [7:0] wdata;
    } txn_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ROM_AW-1:0] start_idx = '0;
    logic              busy, seq_done, seq_err;
    logic [ROM_AW-1:0] err_idx, rom_addr;
    logic [7:0]        last_rdata;
    logic [25:0]       rom_data;
    logic              bus_ena, bus_sel;
    logic [7:0]        bus_addr, bus_wdata;
    logic [7:0]        bus_rdata = 8'h00;
    logic              bus_data_ready = 1'b0;
    logic              bus_done = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned cyc = 0;

    logic [25:0] rom [0:63];
    logic [7:0]  regs [0:255];
    logic [7:0]  resp_q[$];
    txn_t        act_q[$];
    txn_t        exp_q[$];
    int unsigned ena_cyc[$];
    logic [7:0]  exp_last = 8'h00;
    int          pend_cnt = 0;
    txn_t        cur;
    int          stable_err = 0;
    int          overlap_err = 0;
    bit          spur_req = 1'b0;

    ld3320_cmd_sequencer #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ), .ROM_AW(ROM_AW), .POLL_MAX(POLL_MAX), .POLL_GAP_MS(POLL_GAP_MS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_idx(start_idx),
        .busy(busy), .seq_done(seq_done), .seq_err(seq_err), .err_idx(err_idx),
        .last_rdata(last_rdata), .rom_addr(rom_addr), .rom_data(rom_data),
        .bus_ena(bus_ena), .bus_sel(bus_sel), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_data_ready(bus_data_ready), .bus_done(bus_done)
    );

    always #5 clk = ~clk;

    // Cycle counter for timing measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous command ROM.
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Bus driver model: fixed latency, records transactions, checks field stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_cnt = 0;
            bus_done = 1'b0;
            bus_data_ready = 1'b0;
        end else begin
            bus_done = 1'b0;
            bus_data_ready = 1'b0;
            if (pend_cnt > 0) begin
                if ({bus_sel, bus_addr, bus_wdata} !== cur) stable_err++;
                pend_cnt--;
                if (pend_cnt == 0) begin
                    bus_done = 1'b1;
                    if (!cur.sel) begin
                        if (resp_q.size() > 0) bus_rdata = resp_q.pop_front();
                        else                   bus_rdata = regs[cur.addr];
                        bus_data_ready = 1'b1;
                    end else begin
                        regs[cur.addr] = cur.wdata;
                    end
                end
            end else if (spur_req) begin
                bus_done = 1'b1;
                spur_req = 1'b0;
            end
            if (bus_ena === 1'b1) begin
                if (pend_cnt > 0) overlap_err++;
                cur.sel = bus_sel;
                cur.addr = bus_addr;
                cur.wdata = bus_wdata;
                act_q.push_back(cur);
                ena_cyc.push_back(cyc);
                pend_cnt = LAT;
            end
        end
    end

    // Reference: interpret the command table the way the chip sequence is meant to run.
    task automatic model_run(input int idx, output int res, output logic [5:0] eidx);
        logic [7:0] mregs [0:255];
        logic [7:0] mresp[$];
        logic [25:0] e;
        logic [7:0] a, d, m, v;
        int i, fails;
        txn_t t;
        mregs = regs;
        mresp = resp_q;
        exp_q.delete();
        i = idx;
        res = 0;
        eidx = '0;
        for (int step = 0; step < 64 && res == 0; step++) begin
            e = rom[i];
            a = e[23:16];
            d = e[15:8];
            m = e[7:0];
            if (e[25:24] == OP_WR) begin
                t = '{sel: 1'b1, addr: a, wdata: d};
                exp_q.push_back(t);
                mregs[a] = d;
`ifdef LD3320_SEQ_READBACK_EN
                t = '{sel: 1'b0, addr: a, wdata: d};
                exp_q.push_back(t);
                v = (mresp.size() > 0) ? mresp.pop_front() : mregs[a];
                exp_last = v;
                if (v != d) begin res = 2; eidx = 6'(i); end
`endif
            end else if (e[25:24] == OP_POLL) begin
                fails = 0;
                while (1) begin
                    t = '{sel: 1'b0, addr: a, wdata: d};
                    exp_q.push_back(t);
                    v = (mresp.size() > 0) ? mresp.pop_front() : mregs[a];
                    exp_last = v;
                    if ((v & m) == (d & m)) break;
                    fails++;
                    if (fails == POLL_MAX) begin res = 2; eidx = 6'(i); break; end
                end
            end else if (e[25:24] == OP_END) begin
                res = 1;
            end
            if (res == 0) i = (i + 1) % 64;
        end
    endtask

    task automatic pulse_start(input int idx);
        @(negedge clk);
        start = 1'b1;
        start_idx = 6'(idx);
        @(negedge clk);
        start = 1'b0;
    endtask

    // 1 = seq_done seen, 2 = seq_err seen, 0 = budget expired.
    task automatic wait_end(input int budget, output int res);
        res = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (seq_done === 1'b1) begin res = 1; break; end
            if (seq_err === 1'b1) begin res = 2; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, seq_done, seq_err, bus_ena, bus_sel} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 00000", {busy, seq_done, seq_err, bus_ena, bus_sel});
        end
        n_cmp++;
        if ({err_idx, rom_addr, last_rdata, bus_addr, bus_wdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_values got err_idx=%h rom_addr=%h last_rdata=%h bus_addr=%h bus_wdata=%h want all 0",
                     err_idx, rom_addr, last_rdata, bus_addr, bus_wdata);
        end
        rst_n = 1'b1;
        exp_last = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_write();
        int res, got;
        logic [5:0] eidx;
        rom[0] = {OP_WR, 8'h17, 8'h35, 8'h00};
        rom[1] = {OP_WR, 8'hBD, 8'h00, 8'h00};
        rom[2] = {OP_END, 24'h0};
        model_run(0, res, eidx);
        act_q.delete();
        pulse_start(0);
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy got %b want 1", busy); end
        wait_end(2000, got);
        n_cmp++;
        if (got !== res) begin n_bad++; $display("FAIL basic_result got %0d want %0d", got, res); end
        n_cmp++;
        if (act_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL basic_txn_count got %0d want %0d", act_q.size(), exp_q.size());
        end
        n_cmp++;
        if (act_q.size() < 1 || act_q[0] !== txn_t'({1'b1, 8'h17, 8'h35})) begin
            n_bad++; $display("FAIL basic_first_write got %h want %h", (act_q.size() > 0) ? act_q[0] : '0, {1'b1, 8'h17, 8'h35});
        end
        n_cmp++;
        if (act_q.size() < exp_q.size() || act_q[exp_q.size() - 1].addr !== 8'hBD) begin
            n_bad++; $display("FAIL basic_last_addr want BD");
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, seq_done, seq_err} !== 3'b000) begin
            n_bad++; $display("FAIL basic_idle got busy/done/err=%b want 000", {busy, seq_done, seq_err});
        end
        n_cmp++;
        if (stable_err !== 0) begin n_bad++; $display("FAIL basic_hold got %0d unstable cycles want 0", stable_err); end
    endtask

    task automatic test_poll();
        int res, got, gap;
        logic [5:0] eidx;
        rom[4] = {OP_POLL, 8'hB2, 8'h21, 8'hFF};
        rom[5] = {OP_END, 24'h0};
        resp_q = '{8'h00, 8'h00, 8'h21};
        model_run(4, res, eidx);
        act_q.delete();
        ena_cyc.delete();
        pulse_start(4);
        wait_end(10000, got);
        n_cmp++;
        if (got !== 1) begin n_bad++; $display("FAIL poll_result got %0d want 1", got); end
        n_cmp++;
        if (act_q.size() !== 3) begin n_bad++; $display("FAIL poll_reads got %0d want 3", act_q.size()); end
        n_cmp++;
        if (last_rdata !== 8'h21) begin n_bad++; $display("FAIL poll_last_rdata got %h want 21", last_rdata); end
        for (int k = 1; k < ena_cyc.size(); k++) begin
            gap = int'(ena_cyc[k] - ena_cyc[k-1]);
            n_cmp++;
            if (gap < MS || gap > MS + LAT + 20) begin
                n_bad++; $display("FAIL poll_gap got %0d cycles want %0d..%0d", gap, MS, MS + LAT + 20);
            end
        end
        resp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_poll_timeout();
        int res, got;
        logic [5:0] eidx;
        rom[8] = {OP_POLL, 8'hB2, 8'h21, 8'hFF};
        rom[9] = {OP_END, 24'h0};
        regs[8'hB2] = 8'h00;
        resp_q.delete();
        model_run(8, res, eidx);
        act_q.delete();
        pulse_start(8);
        wait_end(10000, got);
        n_cmp++;
        if (got !== 2) begin n_bad++; $display("FAIL timeout_result got %0d want 2", got); end
        n_cmp++;
        if (err_idx !== 6'd8) begin n_bad++; $display("FAIL timeout_err_idx got %0d want 8", err_idx); end
        n_cmp++;
        if (act_q.size() !== POLL_MAX) begin n_bad++; $display("FAIL timeout_reads got %0d want %0d", act_q.size(), POLL_MAX); end
        @(negedge clk);
        n_cmp++;
        if ({seq_err, busy} !== 2'b00) begin n_bad++; $display("FAIL timeout_pulse got err/busy=%b want 00", {seq_err, busy}); end
        n_cmp++;
        if (err_idx !== 6'd8) begin n_bad++; $display("FAIL timeout_err_hold got %0d want 8", err_idx); end
    endtask

    task automatic measure_gap(input int idx, output int gap);
        int t0;
        t0 = -1;
        gap = -1;
        pulse_start(idx);
        for (int k = 0; k < 8000; k++) begin
            if (t0 < 0 && rom_addr == 6'(idx)) t0 = k;
            if (t0 >= 0 && rom_addr == 6'(idx + 1)) begin gap = k - t0; break; end
            if (k == 2000) spur_req = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_delay();
        int res, got, gap5, gap0;
        logic [5:0] eidx;
        rom[40] = {OP_DLY, 16'h0005, 8'h00};
        rom[41] = {OP_WR, 8'h20, 8'h5A, 8'h00};
        rom[42] = {OP_END, 24'h0};
        rom[44] = {OP_DLY, 16'h0000, 8'h00};
        rom[45] = {OP_END, 24'h0};
        model_run(40, res, eidx);
        act_q.delete();
        measure_gap(40, gap5);
        wait_end(2000, got);
        n_cmp++;
        if (got !== res) begin n_bad++; $display("FAIL delay_result got %0d want %0d", got, res); end
        n_cmp++;
        if (act_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL delay_spurious_done got %0d txns want %0d", act_q.size(), exp_q.size());
        end
        @(negedge clk);
        measure_gap(44, gap0);
        wait_end(200, got);
        n_cmp++;
        if (got !== 1) begin n_bad++; $display("FAIL delay0_result got %0d want 1", got); end
        n_cmp++;
        if (gap0 < 0 || gap0 > 4) begin n_bad++; $display("FAIL delay0_gap got %0d want <=4", gap0); end
        n_cmp++;
        if (gap5 - gap0 < 5 * MS - 2 || gap5 - gap0 > 5 * MS + 2) begin
            n_bad++; $display("FAIL delay5_wait got %0d want %0d+-2", gap5 - gap0, 5 * MS);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int res, got;
        logic [5:0] eidx;
        model_run(40, res, eidx);
        act_q.delete();
        pulse_start(40);
        repeat (200) @(negedge clk);
        pulse_start(0);
        wait_end(8000, got);
        n_cmp++;
        if (got !== res) begin n_bad++; $display("FAIL busy_start_result got %0d want %0d", got, res); end
        n_cmp++;
        if (act_q.size() !== exp_q.size() || (act_q.size() > 0 && act_q[0].addr !== 8'h20)) begin
            n_bad++; $display("FAIL busy_start_ignored got %0d txns want %0d to addr 20", act_q.size(), exp_q.size());
        end
        @(negedge clk);
        model_run(0, res, eidx);
        act_q.delete();
        pulse_start(0);
        wait_end(2000, got);
        n_cmp++;
        if (got !== res || act_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL restart_run got res=%0d txns=%0d want res=%0d txns=%0d", got, act_q.size(), res, exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int res, got, k;
        logic [5:0] eidx;
        act_q.delete();
        pulse_start(0);
        for (k = 0; k < 50 && act_q.size() == 0; k++) @(negedge clk);
        n_cmp++;
        if (act_q.size() == 0) begin n_bad++; $display("FAIL midreset_issue got no bus_ena within 50 cycles want one"); end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus_ena, busy, seq_done} !== 3'b000) begin
            n_bad++; $display("FAIL midreset_async got ena/busy/done=%b want 000", {bus_ena, busy, seq_done});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_last = 8'h00;
        @(negedge clk);
        n_cmp++;
        if ({rom_addr, last_rdata, bus_sel} !== '0) begin
            n_bad++; $display("FAIL midreset_clear got rom_addr=%h last_rdata=%h sel=%b want 0", rom_addr, last_rdata, bus_sel);
        end
        model_run(0, res, eidx);
        act_q.delete();
        pulse_start(0);
        wait_end(2000, got);
        n_cmp++;
        if (got !== res || act_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL midreset_rerun got res=%0d txns=%0d want res=%0d txns=%0d", got, act_q.size(), res, exp_q.size());
        end
        @(negedge clk);
    endtask

`ifdef LD3320_SEQ_READBACK_EN
    task automatic test_readback();
        int got;
        rom[50] = {OP_WR, 8'h17, 8'h35, 8'h00};
        rom[51] = {OP_END, 24'h0};
        resp_q = '{8'h34};
        act_q.delete();
        pulse_start(50);
        wait_end(2000, got);
        n_cmp++;
        if (got !== 2 || err_idx !== 6'd50) begin
            n_bad++; $display("FAIL readback_bad got res=%0d err_idx=%0d want 2/50", got, err_idx);
        end
        n_cmp++;
        if (last_rdata !== 8'h34 || act_q.size() !== 2) begin
            n_bad++; $display("FAIL readback_data got rdata=%h txns=%0d want 34/2", last_rdata, act_q.size());
        end
        resp_q.delete();
        @(negedge clk);
        pulse_start(50);
        wait_end(2000, got);
        n_cmp++;
        if (got !== 1 || last_rdata !== 8'h35) begin
            n_bad++; $display("FAIL readback_good got res=%0d rdata=%h want 1/35", got, last_rdata);
        end
        exp_last = 8'h35;
        @(negedge clk);
    endtask
`endif

    task automatic test_random();
        int n, res, got, f, base;
        logic [5:0] eidx;
        logic [7:0] a, d, m;
        base = 16;
        for (int it = 0; it < 8; it++) begin
            resp_q.delete();
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) begin
                a = 8'($urandom);
                d = 8'($urandom);
                case ($urandom_range(0, 3))
                    0, 1: begin
                        rom[base + j] = {OP_WR, a, d, 8'h00};
`ifdef LD3320_SEQ_READBACK_EN
                        resp_q.push_back(d);
`endif
                    end
                    2: begin
                        m = 8'($urandom) | 8'h01;
                        f = $urandom_range(0, 2);
                        if (j == n - 1 && $urandom_range(0, 3) == 0) f = POLL_MAX;
                        rom[base + j] = {OP_POLL, a, d, m};
                        for (int k = 0; k < f; k++) resp_q.push_back(((d ^ m) & m) | (8'($urandom) & ~m));
                        if (f < POLL_MAX) resp_q.push_back((d & m) | (8'($urandom) & ~m));
                    end
                    default: rom[base + j] = {OP_DLY, 16'h0000, 8'h00};
                endcase
            end
            rom[base + n] = {OP_END, 24'h0};
            model_run(base, res, eidx);
            act_q.delete();
            pulse_start(base);
            wait_end(20000, got);
            n_cmp++;
            if (got !== res) begin n_bad++; $display("FAIL rand%0d_result got %0d want %0d", it, got, res); end
            n_cmp++;
            if (err_idx !== eidx) begin n_bad++; $display("FAIL rand%0d_err_idx got %0d want %0d", it, err_idx, eidx); end
            n_cmp++;
            if (last_rdata !== exp_last) begin n_bad++; $display("FAIL rand%0d_last_rdata got %h want %h", it, last_rdata, exp_last); end
            n_cmp++;
            if (act_q.size() !== exp_q.size()) begin
                n_bad++; $display("FAIL rand%0d_txn_count got %0d want %0d", it, act_q.size(), exp_q.size());
            end
            for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
                n_cmp++;
                if (act_q[k].sel !== exp_q[k].sel || act_q[k].addr !== exp_q[k].addr ||
                    (exp_q[k].sel && act_q[k].wdata !== exp_q[k].wdata)) begin
                    n_bad++; $display("FAIL rand%0d_txn%0d got %h want %h", it, k, act_q[k], exp_q[k]);
                end
            end
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0) begin n_bad++; $display("FAIL rand%0d_busy got %b want 0", it, busy); end
            resp_q.delete();
        end
        n_cmp++;
        if (stable_err !== 0 || overlap_err !== 0) begin
            n_bad++; $display("FAIL bus_protocol got unstable=%0d overlap=%0d want 0/0", stable_err, overlap_err);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = {OP_END, 24'h0};
        for (int i = 0; i < 256; i++) regs[i] = 8'h00;
        test_reset();
        test_basic_write();
        test_poll();
        test_poll_timeout();
        test_delay();
        test_back_to_back();
        test_reset_mid();
`ifdef LD3320_SEQ_READBACK_EN
        test_readback();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
